// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 front end.
//   fetch_state_t : fetch FSM states (request, wait for data, drop stale data)
//   NOP_INSTR     : bubble word (addi x0,x0,0)
//   OP_*          : major opcodes seen by decode
//   *_LSB/*_MSB   : bit positions of the instruction fields
//   align_word()  : clears the byte-offset bits of an address
package rv_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID instruction register: holds the fetched word, its PC and a valid bit.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : kill the held instruction (IR becomes a bubble)
//   load            : capture load_instr/load_pc and mark valid
//   consume         : decode took the instruction, clear valid
//   valid/pc/instr  : register contents
// Priority is flush > load > consume.
module if_id_reg import rv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic        valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= RESET_PC;
      instr_reg <= BUBBLE;
    end else if (flush) begin
      // PC of the killed slot is left as-is; only the word and valid matter.
      valid_reg <= 1'b0;
      instr_reg <= BUBBLE;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end else if (consume) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register.
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  : word fetch request (addr = pc)
//   imem_rsp_valid, imem_rsp_data    : one-cycle read response
//   stall                            : decode cannot take IR this cycle
//   br_taken, br_target              : redirect/flush from execute
//   if_valid, if_pc, if_instr        : IF/ID register contents
//   opcode..rs2                      : combinational field slices of IR
//   misalign_err                     : pulse when a redirect target is unaligned
// At most one request is outstanding. A redirect while a request is in
// flight sends the FSM to S_DROP so the stale response is swallowed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        misalign_err
);
  import rv_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         misalign_reg;
  logic         req_valid;
  logic         handshake;
  logic         ir_load;
  logic         ir_consume;

  // Only request when the response is guaranteed a free IR slot.
  assign req_valid  = (state_reg == S_REQ) && (!if_valid || !stall);
  assign handshake  = req_valid && imem_req_ready;
  assign ir_consume = if_valid && !stall;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_load    = 1'b0;
    if (br_taken) begin
      pc_next = align_word(br_target);
      case (state_reg)
        S_REQ:   state_next = handshake ? S_DROP : S_REQ;
        S_WAIT:  state_next = imem_rsp_valid ? S_REQ : S_DROP;
        // A response landing in the same cycle retires the stale request,
        // so there is nothing left to drop.
        S_DROP:  state_next = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_REQ: begin
          if (handshake) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            ir_load    = 1'b1;
            pc_next    = pc_reg + PC_STEP;
            state_next = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_next = S_REQ;
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      misalign_reg <= br_taken && (br_target[1:0] != 2'b00);
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .BUBBLE   (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (br_taken),
    .load       (ir_load),
    .consume    (ir_consume),
    .load_instr (imem_rsp_data),
    .load_pc    (pc_reg),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

  assign imem_req_valid = req_valid;
  assign imem_addr      = pc_reg;
  assign misalign_err   = misalign_reg;

  assign opcode = if_instr[OPCODE_MSB:OPCODE_LSB];
  assign rd     = if_instr[RD_MSB:RD_LSB];
  assign funct3 = if_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1    = if_instr[RS1_MSB:RS1_LSB];
  assign rs2    = if_instr[RS2_MSB:RS2_LSB];
  assign funct7 = if_instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level model (queue of
// outstanding requests, each either live or cancelled by a redirect).
module tb_fetch_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        stall = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .misalign_err(misalign_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] addr; logic doomed; } req_t;
  req_t        inflight[$];
  logic [31:0] m_pc, m_ir, m_ir_pc;
  logic        m_valid, m_mis;

  // ---------------- memory + observation ----------------
  int cyc = 0;
  int rsp_due = -1;
  logic [31:0] rsp_addr;
  int lat = 1;
  bit lat_rand = 0;
  int stall_pct = 0, ready_pct = 100, br_pct = 0;
  logic [31:0] dpc[$];     // PCs of instructions the DUT delivered
  int          dcyc[$];    // cycle each delivery became visible
  logic [31:0] dhs[$];     // addresses of DUT handshakes
  int          mis_seen = 0;
  logic        pv = 1'b0, pcons = 1'b0, smp_if_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return t;
  endfunction

  // One clock cycle: check state at negedge, drive inputs, check the
  // request strobe, then advance the model. Negative args mean random.
  task automatic step(input int st, input int rdy, input int b, input logic [31:0] t);
    logic s_i, r_i, b_i, rsp_i, exp_req, hs;
    logic [31:0] t_i, pc_old, data_i;
    int lat_i;
    req_t head;
    @(negedge clk);
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("if_pc", if_pc, m_ir_pc);
    check("if_instr", if_instr, m_ir);
    check("imem_addr", imem_addr, m_pc);
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
    check("fields", {opcode, funct3, funct7, rd, rs1, rs2},
          {m_ir[6:0], m_ir[14:12], m_ir[31:25], m_ir[11:7], m_ir[19:15], m_ir[24:20]});
    smp_if_valid = if_valid;
    if (misalign_err) mis_seen++;
    if (if_valid && (!pv || pcons)) begin
      dpc.push_back(if_pc);
      dcyc.push_back(cyc);
    end

    s_i   = (st  < 0) ? (int'($urandom_range(99)) < stall_pct) : st[0];
    r_i   = (rdy < 0) ? (int'($urandom_range(99)) < ready_pct) : rdy[0];
    b_i   = (b   < 0) ? (int'($urandom_range(99)) < br_pct)    : b[0];
    t_i   = (b   < 0) ? rand_target() : t;
    rsp_i = (rsp_due == cyc);
    data_i = rsp_i ? mem_word(rsp_addr) : $urandom;
    stall = s_i; imem_req_ready = r_i; br_taken = b_i; br_target = t_i;
    imem_rsp_valid = rsp_i; imem_rsp_data = data_i;
    #1;
    exp_req = (inflight.size() == 0) && (!m_valid || !s_i);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (imem_req_valid && r_i) dhs.push_back(imem_addr);
    hs = exp_req && r_i;

    pc_old = m_pc;
    if (m_valid && !s_i) m_valid = 1'b0;
    if (rsp_i) begin
      rsp_due = -1;
      if (inflight.size() > 0) begin
        head = inflight.pop_front();
        if (!head.doomed && !b_i) begin
          m_ir = data_i; m_ir_pc = head.addr; m_valid = 1'b1;
          m_pc = head.addr + 32'd4;
        end
      end
    end
    if (hs) begin
      lat_i = lat_rand ? int'($urandom_range(1, 4)) : lat;
      inflight.push_back('{addr: pc_old, doomed: b_i});
      rsp_due = cyc + lat_i;
      rsp_addr = pc_old;
    end
    if (b_i) begin
      foreach (inflight[i]) inflight[i].doomed = 1'b1;
      m_pc = {t_i[31:2], 2'b00};
      m_valid = 1'b0;
      m_ir = NOP_INSTR;
    end
    m_mis = b_i && (t_i[1:0] != 2'b00);
    pv = if_valid;
    pcons = if_valid && !s_i;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    br_taken = 1'b0; br_target = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    inflight.delete();
    rsp_due = -1;
    m_pc = 32'h0; m_ir = NOP_INSTR; m_ir_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    pv = 1'b0; pcons = 1'b0;
    #1;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_misalign", 32'(misalign_err), 32'd0);
  endtask

  int d0, k, ms;
  logic [31:0] sv_instr, sv_pc, a0;

  initial begin
    do_reset();

    // Zero-wait stream
    lat = 1; lat_rand = 0;
    d0 = dpc.size();
    for (int i = 0; i < 20 && dpc.size() < d0 + 3; i++) step(0, 1, 0, 0);
    check("stream_count", 32'(dpc.size() - d0), 32'd3);
    if (dpc.size() >= d0 + 3) begin
      check("stream_pc0", dpc[d0], 32'h0);
      check("stream_pc1", dpc[d0+1], 32'h4);
      check("stream_pc2", dpc[d0+2], 32'h8);
      check("stream_gap1", 32'(dcyc[d0+1] - dcyc[d0]), 32'd2);
      check("stream_gap2", 32'(dcyc[d0+2] - dcyc[d0+1]), 32'd2);
    end
    check("dec_opcode", 32'(opcode), 32'(OP_R));
    check("dec_rd", 32'(rd), 32'd3);
    check("dec_rs1", 32'(rs1), 32'd1);
    check("dec_rs2", 32'(rs2), 32'd2);
    check("dec_funct7", 32'(funct7), 32'd0);
    check("dec_funct3", 32'(funct3), 32'd0);

    // Stall hold
    smp_if_valid = 1'b0;
    for (int i = 0; i < 10 && !smp_if_valid; i++) step(1, 1, 0, 0);
    check("stall_live", 32'(if_valid), 32'd1);
    sv_instr = if_instr; sv_pc = if_pc;
    repeat (5) step(1, 1, 0, 0);
    check("stall_instr", if_instr, sv_instr);
    check("stall_pc", if_pc, sv_pc);
    check("stall_req", 32'(imem_req_valid), 32'd0);
    check("stall_addr", imem_addr, sv_pc + 32'd4);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("stall_release_valid", 32'(smp_if_valid), 32'd0);

    // Redirect while waiting for the response to pc 0x8
    do_reset();
    lat = 1;
    d0 = dpc.size();
    for (int i = 0; i < 20 && dpc.size() < d0 + 1; i++) step(0, 1, 0, 0);
    lat = 3;
    for (int i = 0; i < 20 && dpc.size() < d0 + 2; i++) step(0, 1, 0, 0);
    check("bw_pending_addr", dhs[$], 32'h8);
    k = dhs.size();
    step(0, 1, 1, 32'h40);
    lat = 1;
    for (int i = 0; i < 20 && dpc.size() < d0 + 3; i++) step(0, 1, 0, 0);
    check("bw_count", 32'(dpc.size() - d0), 32'd3);
    if (dhs.size() > k) check("bw_next_req", dhs[k], 32'h40);
    if (dpc.size() >= d0 + 3) check("bw_first_pc", dpc[d0+2], 32'h40);

    // Redirect coincident with response, misaligned target
    lat = 2;
    for (int i = 0; i < 20 && inflight.size() == 0; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 20 && rsp_due != cyc; i++) step(0, 1, 0, 0);
    check("bc_rsp_aligned", 32'(rsp_due == cyc), 32'd1);
    d0 = dpc.size(); k = dhs.size(); ms = mis_seen;
    step(0, 1, 1, 32'h103);
    lat = 1;
    for (int i = 0; i < 20 && dpc.size() <= d0; i++) step(0, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    if (dhs.size() > k) check("bc_next_req", dhs[k], 32'h100);
    else check("bc_next_req_seen", 32'd0, 32'd1);
    if (dpc.size() > d0) check("bc_first_pc", dpc[d0], 32'h100);
    else check("bc_delivery_seen", 32'd0, 32'd1);
    check("bc_misalign_pulses", 32'(mis_seen - ms), 32'd1);

    // Wait states: ready low 3 cycles, response 4 cycles after accept
    for (int i = 0; i < 20 && (inflight.size() != 0 || m_valid); i++) step(0, 0, 0, 0);
    a0 = imem_addr;
    lat = 4;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("ws_addr_hold", imem_addr, a0);
    end
    d0 = dpc.size(); k = dhs.size();
    step(0, 1, 0, 0);
    for (int i = 0; i < 10 && dpc.size() <= d0; i++) step(0, 0, 0, 0);
    check("ws_handshakes", 32'(dhs.size() - k), 32'd1);
    check("ws_deliveries", 32'(dpc.size() - d0), 32'd1);
    if (dpc.size() > d0) check("ws_pc", dpc[d0], a0);
    check("ws_pc_next", imem_addr, a0 + 32'd4);

    // Random traffic
    stall_pct = 30; ready_pct = 70; br_pct = 5; lat_rand = 1;
    for (int i = 0; i < 3000; i++) step(-1, -1, -1, 0);
    do_reset();
    for (int i = 0; i < 1500; i++) step(-1, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
